// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory/IO bus.
// Handles address decode, alignment checking and a bus_ready timeout.
module bus_arbiter #(
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_rw,
  input  logic [1:0]  m0_size,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_rw,
  input  logic [1:0]  m1_size,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_rw,
  output logic [1:0]  bus_size,
  output logic        bus_mem_sel,
  output logic        bus_io_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR} state_t;

  state_t            r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_m0_gnt, r_m0_done, r_m0_err;
  logic              r_m1_gnt, r_m1_done, r_m1_err;
  logic [31:0]       r_m0_rdata, r_m1_rdata;
  logic              r_bus_valid, r_bus_rw, r_bus_mem_sel, r_bus_io_sel;
  logic [31:0]       r_bus_addr, r_bus_wdata;
  logic [1:0]        r_bus_size;

  logic              w_pick1;
  logic [31:0]       w_addr, w_wdata;
  logic              w_rw;
  logic [1:0]        w_size;
  logic              w_legal;

  // Winner selection: on a tie the master that did not win last time goes.
  always_comb begin
    w_pick1 = m1_req && (!m0_req || !r_last_grant);
    w_addr  = w_pick1 ? m1_addr  : m0_addr;
    w_wdata = w_pick1 ? m1_wdata : m0_wdata;
    w_rw    = w_pick1 ? m1_rw    : m0_rw;
    w_size  = w_pick1 ? m1_size  : m0_size;
    case (w_size)
      2'd0:    w_legal = 1'b1;
      2'd1:    w_legal = !w_addr[0];
      2'd2:    w_legal = (w_addr[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_cnt         <= '0;
      r_m0_gnt      <= 1'b0;
      r_m0_done     <= 1'b0;
      r_m0_err      <= 1'b0;
      r_m0_rdata    <= '0;
      r_m1_gnt      <= 1'b0;
      r_m1_done     <= 1'b0;
      r_m1_err      <= 1'b0;
      r_m1_rdata    <= '0;
      r_bus_valid   <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_wdata   <= '0;
      r_bus_rw      <= 1'b0;
      r_bus_size    <= '0;
      r_bus_mem_sel <= 1'b0;
      r_bus_io_sel  <= 1'b0;
    end else begin
      r_m0_gnt   <= 1'b0;
      r_m1_gnt   <= 1'b0;
      r_m0_done  <= 1'b0;
      r_m1_done  <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            r_owner      <= w_pick1;
            r_last_grant <= w_pick1;
            r_cnt        <= '0;
            r_m0_gnt     <= !w_pick1;
            r_m1_gnt     <= w_pick1;
            if (w_legal) begin
              r_state       <= S_ACCESS;
              r_bus_valid   <= 1'b1;
              r_bus_addr    <= w_addr;
              r_bus_wdata   <= w_wdata;
              r_bus_rw      <= w_rw;
              r_bus_size    <= w_size;
              r_bus_mem_sel <= (w_addr < IO_BASE);
              r_bus_io_sel  <= (w_addr >= IO_BASE);
            end else begin
              r_state <= S_ERR;
            end
          end
        end
        S_ACCESS: begin
          // A ready on the timeout edge still completes cleanly.
          if (bus_ready || (r_cnt == TO_LAST)) begin
            r_state       <= S_IDLE;
            r_bus_valid   <= 1'b0;
            r_bus_mem_sel <= 1'b0;
            r_bus_io_sel  <= 1'b0;
            r_m0_done     <= !r_owner;
            r_m1_done     <= r_owner;
            r_m0_err      <= !r_owner && !bus_ready;
            r_m1_err      <= r_owner && !bus_ready;
            if (bus_ready && !r_bus_rw) begin
              if (r_owner) r_m1_rdata <= bus_rdata;
              else         r_m0_rdata <= bus_rdata;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ERR: begin
          r_state   <= S_IDLE;
          r_m0_done <= !r_owner;
          r_m1_done <= r_owner;
          r_m0_err  <= !r_owner;
          r_m1_err  <= r_owner;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_gnt      = r_m0_gnt;
  assign m0_done     = r_m0_done;
  assign m0_err      = r_m0_err;
  assign m0_rdata    = r_m0_rdata;
  assign m1_gnt      = r_m1_gnt;
  assign m1_done     = r_m1_done;
  assign m1_err      = r_m1_err;
  assign m1_rdata    = r_m1_rdata;
  assign bus_valid   = r_bus_valid;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_rw      = r_bus_rw;
  assign bus_size    = r_bus_size;
  assign bus_mem_sel = r_bus_mem_sel;
  assign bus_io_sel  = r_bus_io_sel;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: per-scenario tasks plus a completion scoreboard.
module tb_bus_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_rw, m0_gnt, m0_done, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_size;
  logic        m1_req, m1_rw, m1_gnt, m1_done, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_size;
  logic        bus_valid, bus_rw, bus_mem_sel, bus_io_sel, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  bus_size;

  typedef struct {
    int          m;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Slave model: 0 = ready immediately, 1 = never ready, 2 = ready on cycle rdy_k
  int rdy_mode = 0;
  int rdy_k    = 1;
  int acc_cyc  = 0;

  bus_arbiter #(.IO_BASE(32'hFFFF_0000), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw(m0_rw),
    .m0_size(m0_size), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw(m1_rw),
    .m1_size(m1_size), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err),
    .m1_rdata(m1_rdata),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rw(bus_rw), .bus_size(bus_size), .bus_mem_sel(bus_mem_sel),
    .bus_io_sel(bus_io_sel), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (bus_valid) begin
      acc_cyc   = acc_cyc + 1;
      bus_ready = (rdy_mode == 0) || (rdy_mode == 2 && acc_cyc == rdy_k);
    end else begin
      acc_cyc   = 0;
      bus_ready = 1'b0;
    end
  end

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t        e;
    int          gm;
    logic        gerr;
    logic [31:0] grd, other;
    if (m0_done || m1_done) begin
      n_tests++;
      if (m0_done && m1_done) begin
        n_fail++;
        $display("FAIL both_done: m0_done=%b m1_done=%b required one", m0_done, m1_done);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: m0_done=%b m1_done=%b required none", m0_done, m1_done);
      end else begin
        e     = sb.pop_front();
        gm    = m1_done ? 1 : 0;
        gerr  = m1_done ? m1_err : m0_err;
        grd   = m1_done ? m1_rdata : m0_rdata;
        other = m1_done ? m0_rdata : m1_rdata;
        if (gm !== e.m || gerr !== e.err || grd !== e.rdata || other !== 32'h0) begin
          n_fail++;
          $display("FAIL done_check: got m%0d err=%b rdata=%h other_rdata=%h, required m%0d err=%b rdata=%h other_rdata=0",
                   gm, gerr, grd, other, e.m, e.err, e.rdata);
        end
      end
    end
  end

  task automatic set_m(input int m, input logic [31:0] a, input logic [31:0] wd,
                       input logic rw, input logic [1:0] sz);
    if (m == 0) begin
      m0_addr = a; m0_wdata = wd; m0_rw = rw; m0_size = sz;
    end else begin
      m1_addr = a; m1_wdata = wd; m1_rw = rw; m1_size = sz;
    end
  endtask

  task automatic push_exp(input int m, input logic err, input logic [31:0] rd);
    exp_t e;
    e.m = m; e.err = err; e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input int m);
    logic seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      seen = (m == 0) ? m0_gnt : m1_gnt;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL gnt_timeout: m%0d gnt=0 required 1 within 30 cycles", m);
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 60 && sb.size() != 0; c++) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d outstanding completions, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_req = 0; m1_req = 0; bus_rdata = '0; bus_ready = 0;
    set_m(0, 32'h0, 32'h0, 1'b0, 2'd0);
    set_m(1, 32'h0, 32'h0, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus_valid, bus_mem_sel, bus_io_sel, m0_gnt, m1_gnt, m0_done, m1_done} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: %b required 0",
               {bus_valid, bus_mem_sel, bus_io_sel, m0_gnt, m1_gnt, m0_done, m1_done});
    end
    n_tests++;
    if ({bus_addr, bus_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h r0=%h r1=%h required 0",
               bus_addr, bus_wdata, m0_rdata, m1_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_read();
    rdy_mode = 0;
    bus_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    set_m(0, 32'h100, 32'h0, 1'b0, 2'd2);
    m0_req = 1'b1;
    push_exp(0, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    n_tests++;
    if (m0_gnt !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_gnt: m0_gnt=%b required 0", m0_gnt);
    end
    @(negedge clk);
    n_tests++;
    if ({m0_gnt, m1_gnt, bus_valid, bus_mem_sel, bus_io_sel} !== 5'b10110 || bus_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL basic_gnt: gnt0/gnt1/valid/mem/io=%b addr=%h required 10110 addr=00000100",
               {m0_gnt, m1_gnt, bus_valid, bus_mem_sel, bus_io_sel}, bus_addr);
    end
    m0_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (m0_done !== 1'b1) begin
      n_fail++; $display("FAIL basic_done_latency: m0_done=%b required 1", m0_done);
    end
    wait_drain();
  endtask

  task automatic test_err_path();
    logic [31:0] addrs [2] = '{32'hFFFF_0003, 32'h0000_0000};
    logic [1:0]  sizes [2] = '{2'd1, 2'd3};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      set_m(1, addrs[i], 32'h55, 1'b1, sizes[i]);
      m1_req = 1'b1;
      push_exp(1, 1'b1, 32'h0);
      wait_gnt(1);
      m1_req = 1'b0;
      n_tests++;
      if (bus_valid !== 1'b0 || m0_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL err_gnt_%0d: bus_valid=%b m0_gnt=%b required 0 0", i, bus_valid, m0_gnt);
      end
      @(negedge clk);
      n_tests++;
      if (m1_done !== 1'b1 || bus_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL err_done_%0d: m1_done=%b bus_valid=%b required 1 0", i, m1_done, bus_valid);
      end
      wait_drain();
    end
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 0, 1};
    int g = 0;
    rdy_mode = 0;
    bus_rdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    set_m(0, 32'h300, 32'h0, 1'b0, 2'd2);
    set_m(1, 32'h400, 32'h0, 1'b0, 2'd2);
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(order[i], 1'b0, 32'hCAFE_0001);
    for (int c = 0; c < 60 && g < 4; c++) begin
      @(negedge clk);
      if (m0_gnt && m1_gnt) begin
        n_tests++; n_fail++;
        $display("FAIL rr_both_gnt: m0_gnt=1 m1_gnt=1 required at most one");
      end else if (m0_gnt || m1_gnt) begin
        n_tests++;
        if ((m1_gnt ? 1 : 0) != order[g]) begin
          n_fail++;
          $display("FAIL rr_order_%0d: granted m%0d required m%0d", g, m1_gnt ? 1 : 0, order[g]);
        end
        g++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    n_tests++;
    if (g != 4) begin
      n_fail++; $display("FAIL rr_count: %0d grants required 4", g);
    end
    wait_drain();
  endtask

  task automatic test_io_write();
    rdy_mode = 0;
    bus_rdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    set_m(0, 32'hFFFF_0000, 32'h20, 1'b1, 2'd0);
    m0_req = 1'b1;
    push_exp(0, 1'b0, 32'h0);
    wait_gnt(0);
    m0_req = 1'b0;
    n_tests++;
    if ({bus_valid, bus_io_sel, bus_mem_sel, bus_rw} !== 4'b1101 || bus_wdata !== 32'h20 ||
        bus_size !== 2'd0 || bus_addr !== 32'hFFFF_0000) begin
      n_fail++;
      $display("FAIL io_write: valid/io/mem/rw=%b wdata=%h size=%0d addr=%h required 1101 00000020 0 ffff0000",
               {bus_valid, bus_io_sel, bus_mem_sel, bus_rw}, bus_wdata, bus_size, bus_addr);
    end
    wait_drain();
  endtask

  task automatic test_timeout();
    int c;
    int modes [2] = '{1, 2};
    logic [31:0] rds [2] = '{32'h0, 32'h1234_5678};
    logic        errs [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      rdy_mode = modes[i];
      rdy_k = 15;
      bus_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      set_m(0, 32'h200, 32'h0, 1'b0, 2'd2);
      m0_req = 1'b1;
      push_exp(0, errs[i], rds[i]);
      wait_gnt(0);
      m0_req = 1'b0;
      c = 0;
      while (!m0_done && c < 40) begin
        @(negedge clk);
        c++;
      end
      n_tests++;
      if (c != 15) begin
        n_fail++;
        $display("FAIL timeout_latency_%0d: done %0d cycles after gnt required 15", i, c);
      end
      wait_drain();
    end
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid_access();
    logic seen0 = 1'b0, seen1 = 1'b0;
    rdy_mode = 1;
    @(posedge clk); #1;
    set_m(0, 32'h700, 32'h77, 1'b1, 2'd2);
    m0_req = 1'b1;
    wait_gnt(0);
    m0_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus_valid, bus_mem_sel, bus_io_sel, bus_rw} !== 4'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_async: valid/mem/io/rw=%b addr=%h wdata=%h required 0",
               {bus_valid, bus_mem_sel, bus_io_sel, bus_rw}, bus_addr, bus_wdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    repeat (20) @(negedge clk);
    bus_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    set_m(0, 32'h500, 32'h0, 1'b0, 2'd2);
    set_m(1, 32'h600, 32'h0, 1'b0, 2'd2);
    m0_req = 1'b1; m1_req = 1'b1;
    push_exp(0, 1'b0, 32'h0BAD_F00D);
    push_exp(1, 1'b0, 32'h0BAD_F00D);
    for (int c = 0; c < 30 && !(seen0 && seen1); c++) begin
      @(negedge clk);
      if ((m0_gnt || m1_gnt) && !seen0 && !seen1) begin
        n_tests++;
        if (m0_gnt !== 1'b1) begin
          n_fail++; $display("FAIL rst_first_gnt: m1 granted first required m0");
        end
      end
      if (m0_gnt) begin seen0 = 1'b1; m0_req = 1'b0; end
      if (m1_gnt) begin seen1 = 1'b1; m1_req = 1'b0; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_err_path();
    test_round_robin();
    test_io_write();
    test_timeout();
    test_reset_mid_access();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, single-slave-bus arbiter for the shared system memory bus.
- The core (master 0) and a future DMA/debug port (master 1) both reach MemoryController and IOController through it, one transaction at a time.
- Functions: round-robin arbitration, address decode (memory vs IO select), alignment checking, and a ready-timeout so a dead slave cannot hang the core.

Parameters:
IO_BASE, 32'hFFFF_0000, addresses >= IO_BASE select IO, others select memory
TIMEOUT, 15, max cycles waiting for bus_ready before error completion (1..255)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
m0_req  in  1  master 0 request, level
m0_addr  in  32  master 0 byte address
m0_wdata  in  32  master 0 write data
m0_rw  in  1  1=write, 0=read
m0_size  in  2  0=byte, 1=half, 2=word, 3=illegal
m0_gnt  out  1  one-cycle pulse: request accepted
m0_done  out  1  one-cycle pulse: transaction complete
m0_err  out  1  valid with m0_done: misaligned/illegal/timeout
m0_rdata  out  32  read data, valid with m0_done
m1_* (req, addr, wdata, rw, size, gnt, done, err, rdata), same widths/meaning for master 1
bus_valid  out  1  bus transaction in progress
bus_addr  out  32  latched address
bus_wdata  out  32  latched write data
bus_rw  out  1  latched direction
bus_size  out  2  latched size
bus_mem_sel  out  1  memory selected (bus_valid && addr < IO_BASE)
bus_io_sel  out  1  IO selected (bus_valid && addr >= IO_BASE)
bus_rdata  in  32  slave read data
bus_ready  in  1  slave completion, sampled in ACCESS

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; last_grant=1 so master 0 wins first tie; timeout counter 0. Reset mid-ACCESS aborts: no done/err pulse, bus_valid drops at once.
- States:
  - IDLE: evaluate req at each edge. If any req: choose winner and latch its addr/wdata/rw/size.
    - Legal and aligned -> ACCESS, with gnt pulse and bus outputs driven in the first ACCESS cycle.
    - Illegal or misaligned -> ERR.
  - ACCESS: bus_valid=1, counter increments each cycle.
    - bus_ready=1 at an edge -> IDLE; winner's done=1, err=0, rdata=bus_rdata (writes: rdata=0) for one cycle.
    - Else counter reaches TIMEOUT -> IDLE; done=1, err=1, rdata=0.
    - bus_ready wins over timeout on the same edge.
  - ERR: gnt=1 for one cycle, no bus activity (bus_valid=0) -> IDLE; done=1, err=1, rdata=0.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0; size 3 always illegal.
- Arbitration:
  - Single requester wins.
  - Both requesting: master != last_grant wins; last_grant updates on every grant, including ERR.
- Latency: req seen at edge N -> gnt after edge N+1 -> done no earlier than after edge N+2 (bus_ready high in the first ACCESS cycle).
- Requester protocol:
  - Hold req, addr, wdata, rw, size stable until gnt; inputs are ignored after latch.
  - req still high in the done cycle = new back-to-back request, arbitrated at the next edge.
- A losing master's req is held pending with no timeout; round-robin guarantees service within one transaction.
- Outputs (gnt/done/err/rdata/bus_*) are registered; bus_mem_sel/bus_io_sel decode from the latched address.
- The done/err/rdata of the non-winning master stay 0; rdata holds 0 outside its done cycle.

Test Plan:
- m0 read word 0x100, bus_ready high in first ACCESS cycle, bus_rdata=0xDEADBEEF -> m0_gnt after edge N+1, m0_done after N+2 with rdata=0xDEADBEEF, err=0, bus_mem_sel=1.
- m0 and m1 both hold req for 4 transactions, ready immediate -> grants in order m0, m1, m0, m1; no cycle with both gnts.
- m1 write half to 0xFFFF_0003 -> ERR path: m1_gnt then m1_done with m1_err=1; bus_valid never asserted. Size=3 to 0x0 gives the same result.
- m0 write 0x20 to IO_BASE (0xFFFF_0000), byte -> bus_io_sel=1, bus_wdata=0x20, bus_rw=1; done after ready.
- m0 read, bus_ready held 0 -> done with err=1, rdata=0 exactly TIMEOUT (15) cycles after entering ACCESS. Ready asserted on cycle 15 -> done, err=0.
- rst pulsed during ACCESS -> all outputs 0 immediately, no done. After release, m1 and m0 request together -> m0 granted first.
